mcp3221_sample_scheduler: RTL and testbench
===========================================

// Module: mcp3221_sample_scheduler
// PURPOSE
//  Periodic sequencer for the MCP3221 I2C read core. Issues a read request every SAMPLE_PERIOD
//  clocks, checks the returned ACKs and frame format, and retries failed reads. Delivers 12-bit
//  samples on a valid/ready stream. Sits between a register/config block and the I2C read core.
// PARAMETERS
//  G_DEVICE_ADDRESS  7'h4D  7-bit I2C address driven to the core
//  G_MAX_RETRIES     3      extra attempts after a failed read (0..15)
//  G_COUNT_WIDTH     32     width of the period counter and the sample_period port
// PORTS
//  clk                      in   1   system clock
//  reset_n                  in   1   async active-low reset
//  enable                   in   1   1 = periodic sampling runs; 0 = stop after current read
//  sample_period            in   CW  clocks between request ticks; values 0 and 1 act as 2
//  core_din_device_address  out  7   address to core (constant G_DEVICE_ADDRESS)
//  core_din_valid           out  1   read request to core
//  core_din_ready           in   1   core accepts request
//  core_dout_register_data  in   16  raw read word from core
//  core_dout_acks_received  in   3   ACK bits from core; all three must be 1
//  core_dout_valid          in   1   core result valid
//  core_dout_ready          out 1    result accepted
//  sample_data              out 12   ADC code (register_data[11:0])
//  sample_error             out 1    1 = retries exhausted; sample_data is then 0
//  sample_valid             out 1    output stream valid
//  sample_ready             in   1   output stream ready
//  overrun_count            out 16   ticks skipped because the scheduler was busy; saturates at 16'hFFFF
//  error_count              out 16   failed attempts (any retry); saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0 except core_din_device_address = G_DEVICE_ADDRESS; state IDLE; period counter 0.
//  Period counter:
//   - Counts only while enable = 1. At sample_period-1 it raises a 1-cycle tick and wraps to 0.
//   - enable = 0 clears the counter. The first tick comes sample_period clocks after enable rises.
//   - A tick outside IDLE/WAIT_TICK increments overrun_count and is dropped (never queued).
//  FSM:
//   - IDLE:      enable = 1 -> WAIT_TICK.
//   - WAIT_TICK: tick -> REQUEST with retry_cnt = 0. enable = 0 -> IDLE.
//   - REQUEST:   core_din_valid = 1 until core_din_valid & core_din_ready, then valid drops
//                next cycle -> WAIT_RESP. Request stays stable while waiting.
//   - WAIT_RESP: core_dout_ready = 1. On core_dout_valid & ready, latch the data and ACKs -> CHECK.
//   - CHECK (1 cycle): pass when acks == 3'b111 and data[15:12] == 4'h0.
//       pass: sample_data <= data[11:0], sample_error <= 0 -> OUTPUT.
//       fail with retry_cnt < G_MAX_RETRIES: error_count++, retry_cnt++ -> REQUEST immediately,
//         without waiting for a tick.
//       fail with retries exhausted: error_count++, sample_data <= 0, sample_error <= 1 -> OUTPUT.
//   - OUTPUT:    sample_valid = 1. Data and error are held stable until sample_valid & sample_ready,
//                then valid drops -> WAIT_TICK (or IDLE if enable = 0).
//  Timing and boundary rules:
//   - Latency from tick to REQUEST is 1 clk. Latency from core result to sample_valid is 2 clk.
//   - enable falling mid-read: the transaction (including retries) completes and its sample is
//     delivered; then -> IDLE. The core is never abandoned mid-handshake.
//   - Tick and sample handshake in the same cycle: the tick counts as an overrun, because the
//     state is still OUTPUT.
//   - Counters saturate; they never wrap.
//   - Async reset mid-transaction returns everything to reset values. The core is reset from the
//     same source.
// TESTING
//  1. sample_period = 100, core returns 16'h0ABC with acks 3'b111 -> sample_data = 12'hABC,
//     error = 0, first sample_valid about 100 clk + core latency after enable; valid again every 100 clk.
//  2. acks = 3'b101 on the first 2 attempts, then 3'b111 / 16'h0123 -> 3 core requests,
//     error_count = 2, sample 12'h123 with error = 0.
//  3. acks always 3'b011, G_MAX_RETRIES = 3 -> 4 requests, error_count = 4, sample_data = 0,
//     sample_error = 1.
//  4. Data 16'hF123 with good ACKs -> treated as a failure and retried. Same outcome as scenario 3
//     if it persists.
//  5. sample_ready held 0 for 350 clk with period 100 -> overrun_count = 3, sample_data held stable.
//  6. enable dropped while in WAIT_RESP -> that sample is delivered, then no further core_din_valid.
//     Reset_n pulsed mid-REQUEST -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/mcp3221_sample_scheduler_if.sv
// Request/response bus between the sample scheduler (master) and the MCP3221 I2C read core (slave).
interface mcp3221_sample_scheduler_if;
    logic [6:0]  core_din_device_address;
    logic        core_din_valid;
    logic        core_din_ready;
    logic [15:0] core_dout_register_data;
    logic [2:0]  core_dout_acks_received;
    logic        core_dout_valid;
    logic        core_dout_ready;

    modport master (
        output core_din_device_address,
        output core_din_valid,
        input  core_din_ready,
        input  core_dout_register_data,
        input  core_dout_acks_received,
        input  core_dout_valid,
        output core_dout_ready
    );

    modport slave (
        input  core_din_device_address,
        input  core_din_valid,
        output core_din_ready,
        output core_dout_register_data,
        output core_dout_acks_received,
        output core_dout_valid,
        input  core_dout_ready
    );
endinterface

// File: rtl/mcp3221_sample_scheduler.sv
// Periodic MCP3221 read sequencer: ticks every sample_period clocks, issues a core read,
// validates ACKs and frame format, retries failures and delivers 12-bit samples.
module mcp3221_sample_scheduler #(
    parameter logic [6:0]  G_DEVICE_ADDRESS = 7'h4D,
    parameter logic [3:0]  G_MAX_RETRIES    = 4'd3,
    parameter int unsigned G_COUNT_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [G_COUNT_WIDTH-1:0] sample_period,
    mcp3221_sample_scheduler_if.master core,
    output logic [11:0]              sample_data,
    output logic                     sample_error,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic [15:0]              overrun_count,
    output logic [15:0]              error_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_TICK = 3'd1;
    localparam logic [2:0] S_REQUEST   = 3'd2;
    localparam logic [2:0] S_WAIT_RESP = 3'd3;
    localparam logic [2:0] S_CHECK     = 3'd4;
    localparam logic [2:0] S_OUTPUT    = 3'd5;

    localparam logic [G_COUNT_WIDTH-1:0] C_CNT_ZERO = {G_COUNT_WIDTH{1'b0}};
    localparam logic [G_COUNT_WIDTH-1:0] C_CNT_ONE  = {{(G_COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [G_COUNT_WIDTH-1:0] C_CNT_TWO  = {{(G_COUNT_WIDTH-2){1'b0}}, 2'b10};

    function automatic logic frame_ok(input logic [15:0] data, input logic [2:0] acks);
        return (acks == 3'b111) && (data[15:12] == 4'h0);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : (value + 16'd1);
    endfunction

    logic [2:0]               state_q, state_d;
    logic [G_COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]               retry_q, retry_d;
    logic                     din_valid_q, din_valid_d;
    logic                     dout_ready_q, dout_ready_d;
    logic [15:0]              rsp_data_q, rsp_data_d;
    logic [2:0]               rsp_acks_q, rsp_acks_d;
    logic [11:0]              sample_data_q, sample_data_d;
    logic                     sample_error_q, sample_error_d;
    logic                     sample_valid_q, sample_valid_d;
    logic [15:0]              overrun_q, overrun_d;
    logic [15:0]              error_q, error_d;
    logic [G_COUNT_WIDTH-1:0] period_last_s;
    logic                     tick_s;

    // Period counter; periods below 2 behave as 2, and >= keeps a shrinking period from overshooting.
    always_comb begin
        period_last_s = C_CNT_ONE;
        tick_s        = 1'b0;
        cnt_d         = cnt_q;
        if (sample_period < C_CNT_TWO) begin
            period_last_s = C_CNT_ONE;
        end else begin
            period_last_s = sample_period - C_CNT_ONE;
        end
        if (!enable) begin
            cnt_d = C_CNT_ZERO;
        end else if (cnt_q >= period_last_s) begin
            tick_s = 1'b1;
            cnt_d  = C_CNT_ZERO;
        end else begin
            cnt_d = cnt_q + C_CNT_ONE;
        end
    end

    // Sequencer next-state; ticks arriving while a read is in flight are counted and dropped.
    always_comb begin
        state_d        = state_q;
        retry_d        = retry_q;
        din_valid_d    = din_valid_q;
        dout_ready_d   = dout_ready_q;
        rsp_data_d     = rsp_data_q;
        rsp_acks_d     = rsp_acks_q;
        sample_data_d  = sample_data_q;
        sample_error_d = sample_error_q;
        sample_valid_d = sample_valid_q;
        overrun_d      = overrun_q;
        error_d        = error_q;

        if (tick_s && (state_q != S_IDLE) && (state_q != S_WAIT_TICK)) begin
            overrun_d = sat_inc16(overrun_q);
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_WAIT_TICK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_TICK: begin
                if (tick_s) begin
                    state_d     = S_REQUEST;
                    retry_d     = 4'd0;
                    din_valid_d = 1'b1;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_TICK;
                end
            end
            S_REQUEST: begin
                if (din_valid_q && core.core_din_ready) begin
                    state_d      = S_WAIT_RESP;
                    din_valid_d  = 1'b0;
                    dout_ready_d = 1'b1;
                end else begin
                    din_valid_d = 1'b1;
                end
            end
            S_WAIT_RESP: begin
                if (core.core_dout_valid && dout_ready_q) begin
                    state_d      = S_CHECK;
                    dout_ready_d = 1'b0;
                    rsp_data_d   = core.core_dout_register_data;
                    rsp_acks_d   = core.core_dout_acks_received;
                end else begin
                    dout_ready_d = 1'b1;
                end
            end
            S_CHECK: begin
                if (frame_ok(rsp_data_q, rsp_acks_q)) begin
                    state_d        = S_OUTPUT;
                    sample_data_d  = rsp_data_q[11:0];
                    sample_error_d = 1'b0;
                    sample_valid_d = 1'b1;
                end else if (retry_q < G_MAX_RETRIES) begin
                    state_d     = S_REQUEST;
                    error_d     = sat_inc16(error_q);
                    retry_d     = retry_q + 4'd1;
                    din_valid_d = 1'b1;
                end else begin
                    state_d        = S_OUTPUT;
                    error_d        = sat_inc16(error_q);
                    sample_data_d  = 12'h000;
                    sample_error_d = 1'b1;
                    sample_valid_d = 1'b1;
                end
            end
            S_OUTPUT: begin
                if (sample_valid_q && sample_ready) begin
                    sample_valid_d = 1'b0;
                    if (enable) begin
                        state_d = S_WAIT_TICK;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    sample_valid_d = 1'b1;
                end
            end
            default: begin
                state_d        = S_IDLE;
                din_valid_d    = 1'b0;
                dout_ready_d   = 1'b0;
                sample_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= C_CNT_ZERO;
            retry_q        <= 4'd0;
            din_valid_q    <= 1'b0;
            dout_ready_q   <= 1'b0;
            rsp_data_q     <= 16'h0000;
            rsp_acks_q     <= 3'b000;
            sample_data_q  <= 12'h000;
            sample_error_q <= 1'b0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 16'h0000;
            error_q        <= 16'h0000;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retry_q        <= retry_d;
            din_valid_q    <= din_valid_d;
            dout_ready_q   <= dout_ready_d;
            rsp_data_q     <= rsp_data_d;
            rsp_acks_q     <= rsp_acks_d;
            sample_data_q  <= sample_data_d;
            sample_error_q <= sample_error_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
            error_q        <= error_d;
        end
    end

    assign core.core_din_device_address = G_DEVICE_ADDRESS;
    assign core.core_din_valid          = din_valid_q;
    assign core.core_dout_ready         = dout_ready_q;
    assign sample_data                  = sample_data_q;
    assign sample_error                 = sample_error_q;
    assign sample_valid                 = sample_valid_q;
    assign overrun_count                = overrun_q;
    assign error_count                  = error_q;

endmodule

// File: tb/tb_mcp3221_sample_scheduler.sv
// Directed bench for mcp3221_sample_scheduler with a one-cycle-latency core response model.
module tb_mcp3221_sample_scheduler;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [31:0] sample_period;
    logic [11:0] sample_data;
    logic        sample_error;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] overrun_count;
    logic [15:0] error_count;

    int tests_run;
    int tests_failed;

    // Core model configuration: the first n_bad requests get the bad response.
    int          n_bad;
    logic [15:0] bad_data;
    logic [2:0]  bad_acks;
    logic [15:0] good_data;
    logic [2:0]  good_acks;
    int          req_count;

    mcp3221_sample_scheduler_if core_bus();

    mcp3221_sample_scheduler #(
        .G_DEVICE_ADDRESS(7'h4D),
        .G_MAX_RETRIES   (4'd3),
        .G_COUNT_WIDTH   (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_period(sample_period),
        .core         (core_bus),
        .sample_data  (sample_data),
        .sample_error (sample_error),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun_count(overrun_count),
        .error_count  (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: accepts a request, answers on the next cycle, holds the answer until taken.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_bus.core_dout_valid         <= 1'b0;
            core_bus.core_dout_register_data <= 16'h0000;
            core_bus.core_dout_acks_received <= 3'b000;
            req_count                        <= 0;
        end else if (core_bus.core_din_valid && core_bus.core_din_ready) begin
            core_bus.core_dout_valid         <= 1'b1;
            core_bus.core_dout_register_data <= (req_count < n_bad) ? bad_data : good_data;
            core_bus.core_dout_acks_received <= (req_count < n_bad) ? bad_acks : good_acks;
            req_count                        <= req_count + 1;
        end else if (core_bus.core_dout_valid && core_bus.core_dout_ready) begin
            core_bus.core_dout_valid <= 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        enable       = 1'b0;
        sample_ready = 1'b1;
        core_bus.core_din_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Steps negedges until the selected signal is high (0: sample_valid, 1: core_din_valid).
    task automatic wait_for(input int sel, input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < budget) begin
            @(negedge clk);
            cycles++;
            seen = (sel == 0) ? sample_valid : core_bus.core_din_valid;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_sample_valid: got %b expected 0", sample_valid); end
        tests_run++; if (sample_data !== 12'h000) begin tests_failed++; $display("FAIL reset_sample_data: got %h expected 000", sample_data); end
        tests_run++; if (sample_error !== 1'b0) begin tests_failed++; $display("FAIL reset_sample_error: got %b expected 0", sample_error); end
        tests_run++; if (core_bus.core_din_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_din_valid: got %b expected 0", core_bus.core_din_valid); end
        tests_run++; if (core_bus.core_dout_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_dout_ready: got %b expected 0", core_bus.core_dout_ready); end
        tests_run++; if (overrun_count !== 16'h0000) begin tests_failed++; $display("FAIL reset_overrun: got %h expected 0000", overrun_count); end
        tests_run++; if (error_count !== 16'h0000) begin tests_failed++; $display("FAIL reset_error_count: got %h expected 0000", error_count); end
        tests_run++; if (core_bus.core_din_device_address !== 7'h4D) begin tests_failed++; $display("FAIL reset_address: got %h expected 4d", core_bus.core_din_device_address); end
    endtask

    task automatic test_basic();
        int cycles; bit seen;
        do_reset();
        sample_period = 32'd100; n_bad = 0; good_data = 16'h0ABC; good_acks = 3'b111;
        enable = 1'b1;
        wait_for(1, 300, cycles, seen);
        tests_run++; if (!seen || cycles != 100) begin tests_failed++; $display("FAIL basic_tick_to_request: got %0d cycles (seen %b) expected 100", cycles, seen); end
        wait_for(0, 300, cycles, seen);
        tests_run++; if (!seen || cycles != 3) begin tests_failed++; $display("FAIL basic_result_latency: got %0d cycles (seen %b) expected 3", cycles, seen); end
        tests_run++; if (sample_data !== 12'hABC) begin tests_failed++; $display("FAIL basic_data: got %h expected abc", sample_data); end
        tests_run++; if (sample_error !== 1'b0) begin tests_failed++; $display("FAIL basic_error: got %b expected 0", sample_error); end
        wait_for(0, 300, cycles, seen);
        tests_run++; if (!seen || cycles != 100) begin tests_failed++; $display("FAIL basic_period: got %0d cycles (seen %b) expected 100", cycles, seen); end
        tests_run++; if (sample_data !== 12'hABC) begin tests_failed++; $display("FAIL basic_data2: got %h expected abc", sample_data); end
        tests_run++; if (error_count !== 16'd0 || overrun_count !== 16'd0) begin tests_failed++; $display("FAIL basic_counters: got err %0d ovr %0d expected 0 0", error_count, overrun_count); end
        tests_run++; if (req_count != 2) begin tests_failed++; $display("FAIL basic_requests: got %0d expected 2", req_count); end
        enable = 1'b0;
    endtask

    task automatic test_retry();
        int cycles; bit seen;
        do_reset();
        sample_period = 32'd10; n_bad = 2;
        bad_data = 16'h0123; bad_acks = 3'b101; good_data = 16'h0123; good_acks = 3'b111;
        enable = 1'b1;
        wait_for(0, 200, cycles, seen);
        tests_run++; if (!seen || cycles != 19) begin tests_failed++; $display("FAIL retry_latency: got %0d cycles (seen %b) expected 19", cycles, seen); end
        tests_run++; if (sample_data !== 12'h123 || sample_error !== 1'b0) begin tests_failed++; $display("FAIL retry_sample: got %h/%b expected 123/0", sample_data, sample_error); end
        tests_run++; if (error_count !== 16'd2) begin tests_failed++; $display("FAIL retry_error_count: got %0d expected 2", error_count); end
        tests_run++; if (req_count != 3) begin tests_failed++; $display("FAIL retry_requests: got %0d expected 3", req_count); end
        // The next tick lands on the handshake cycle and must count as an overrun.
        @(negedge clk);
        tests_run++; if (overrun_count !== 16'd1) begin tests_failed++; $display("FAIL tick_on_handshake_overrun: got %0d expected 1", overrun_count); end
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL retry_valid_drop: got %b expected 0", sample_valid); end
        enable = 1'b0;
    endtask

    task automatic test_exhaust();
        int cycles; bit seen;
        do_reset();
        sample_period = 32'd20; n_bad = 99;
        bad_data = 16'h0456; bad_acks = 3'b011;
        enable = 1'b1;
        wait_for(0, 200, cycles, seen);
        tests_run++; if (!seen || cycles != 32) begin tests_failed++; $display("FAIL exhaust_latency: got %0d cycles (seen %b) expected 32", cycles, seen); end
        tests_run++; if (sample_data !== 12'h000 || sample_error !== 1'b1) begin tests_failed++; $display("FAIL exhaust_sample: got %h/%b expected 000/1", sample_data, sample_error); end
        tests_run++; if (error_count !== 16'd4) begin tests_failed++; $display("FAIL exhaust_error_count: got %0d expected 4", error_count); end
        tests_run++; if (req_count != 4) begin tests_failed++; $display("FAIL exhaust_requests: got %0d expected 4", req_count); end
        enable = 1'b0;
    endtask

    task automatic test_bad_frame();
        int cycles; bit seen;
        do_reset();
        sample_period = 32'd20; n_bad = 1;
        bad_data = 16'h1FFF; bad_acks = 3'b111; good_data = 16'h0FFF; good_acks = 3'b111;
        enable = 1'b1;
        wait_for(0, 200, cycles, seen);
        tests_run++; if (!seen || cycles != 26) begin tests_failed++; $display("FAIL frame_retry_latency: got %0d cycles (seen %b) expected 26", cycles, seen); end
        tests_run++; if (sample_data !== 12'hFFF || sample_error !== 1'b0 || error_count !== 16'd1) begin tests_failed++; $display("FAIL frame_retry_sample: got %h/%b/%0d expected fff/0/1", sample_data, sample_error, error_count); end
        do_reset();
        n_bad = 99; bad_data = 16'hF123; bad_acks = 3'b111;
        enable = 1'b1;
        wait_for(0, 200, cycles, seen);
        tests_run++; if (!seen || cycles != 32) begin tests_failed++; $display("FAIL frame_persist_latency: got %0d cycles (seen %b) expected 32", cycles, seen); end
        tests_run++; if (sample_data !== 12'h000 || sample_error !== 1'b1 || error_count !== 16'd4 || req_count != 4) begin tests_failed++; $display("FAIL frame_persist_sample: got %h/%b/%0d/%0d expected 000/1/4/4", sample_data, sample_error, error_count, req_count); end
        enable = 1'b0;
    endtask

    task automatic test_overrun();
        int cycles; bit seen; bit stable;
        do_reset();
        sample_period = 32'd100; n_bad = 0; good_data = 16'h0456; good_acks = 3'b111;
        sample_ready = 1'b0;
        enable = 1'b1;
        wait_for(0, 300, cycles, seen);
        tests_run++; if (!seen || cycles != 103) begin tests_failed++; $display("FAIL overrun_first_valid: got %0d cycles (seen %b) expected 103", cycles, seen); end
        stable = 1'b1;
        for (int i = 0; i < 350; i++) begin
            @(negedge clk);
            if (sample_valid !== 1'b1 || sample_data !== 12'h456 || sample_error !== 1'b0) stable = 1'b0;
        end
        tests_run++; if (!stable) begin tests_failed++; $display("FAIL overrun_hold_stable: got data %h valid %b expected 456 1", sample_data, sample_valid); end
        tests_run++; if (overrun_count !== 16'd3) begin tests_failed++; $display("FAIL overrun_count: got %0d expected 3", overrun_count); end
        tests_run++; if (req_count != 1) begin tests_failed++; $display("FAIL overrun_no_queue: got %0d requests expected 1", req_count); end
        sample_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (sample_valid !== 1'b0) begin tests_failed++; $display("FAIL overrun_release: got %b expected 0", sample_valid); end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        int cycles; bit seen; bit quiet;
        do_reset();
        sample_period = 32'd20; n_bad = 1;
        bad_data = 16'h0777; bad_acks = 3'b000; good_data = 16'h0777; good_acks = 3'b111;
        enable = 1'b1;
        wait_for(1, 200, cycles, seen);
        tests_run++; if (!seen || cycles != 20) begin tests_failed++; $display("FAIL drop_request_time: got %0d cycles (seen %b) expected 20", cycles, seen); end
        @(negedge clk);
        tests_run++; if (core_bus.core_dout_ready !== 1'b1) begin tests_failed++; $display("FAIL drop_in_wait_resp: got dout_ready %b expected 1", core_bus.core_dout_ready); end
        enable = 1'b0;
        wait_for(0, 100, cycles, seen);
        tests_run++; if (!seen || cycles != 5) begin tests_failed++; $display("FAIL drop_delivery: got %0d cycles (seen %b) expected 5", cycles, seen); end
        tests_run++; if (sample_data !== 12'h777 || sample_error !== 1'b0 || req_count != 2) begin tests_failed++; $display("FAIL drop_sample: got %h/%b/%0d expected 777/0/2", sample_data, sample_error, req_count); end
        quiet = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (core_bus.core_din_valid !== 1'b0 || sample_valid !== 1'b0) quiet = 1'b0;
        end
        tests_run++; if (!quiet || req_count != 2) begin tests_failed++; $display("FAIL drop_stays_idle: got quiet %b requests %0d expected 1 2", quiet, req_count); end
    endtask

    task automatic test_reset_mid_request();
        int cycles; bit seen; bit held;
        do_reset();
        sample_period = 32'd10; n_bad = 0; good_data = 16'h0001; good_acks = 3'b111;
        core_bus.core_din_ready = 1'b0;
        enable = 1'b1;
        wait_for(1, 100, cycles, seen);
        tests_run++; if (!seen || cycles != 10) begin tests_failed++; $display("FAIL stall_request_time: got %0d cycles (seen %b) expected 10", cycles, seen); end
        held = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (core_bus.core_din_valid !== 1'b1 || core_bus.core_din_device_address !== 7'h4D) held = 1'b0;
        end
        tests_run++; if (!held) begin tests_failed++; $display("FAIL stall_request_stable: got valid %b expected 1", core_bus.core_din_valid); end
        tests_run++; if (overrun_count !== 16'd2) begin tests_failed++; $display("FAIL stall_overrun: got %0d expected 2", overrun_count); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (core_bus.core_din_valid !== 1'b0 || core_bus.core_dout_ready !== 1'b0 || sample_valid !== 1'b0) begin tests_failed++; $display("FAIL async_reset_handshake: got %b%b%b expected 000", core_bus.core_din_valid, core_bus.core_dout_ready, sample_valid); end
        tests_run++; if (overrun_count !== 16'd0 || error_count !== 16'd0 || sample_data !== 12'h000 || sample_error !== 1'b0) begin tests_failed++; $display("FAIL async_reset_values: got ovr %0d err %0d data %h e %b expected 0 0 000 0", overrun_count, error_count, sample_data, sample_error); end
        enable = 1'b0;
        core_bus.core_din_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        enable       = 1'b0;
        sample_ready = 1'b1;
        sample_period = 32'd100;
        core_bus.core_din_ready = 1'b1;
        n_bad = 0; bad_data = 16'h0000; bad_acks = 3'b000; good_data = 16'h0000; good_acks = 3'b111;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_basic();
        test_retry();
        test_exhaust();
        test_bad_frame();
        test_overrun();
        test_enable_drop();
        test_reset_mid_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
